// File: rtl/npc_fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package npc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_NUM_DEFAULT = 4;
    localparam int unsigned OFFSET_W          = $clog2(4 * FETCH_NUM_DEFAULT);

    // Byte-offset width of one aligned fetch block of fetch_num 32-bit slots.
    function automatic int unsigned offset_width(input int unsigned fetch_num);
        return $clog2(4 * fetch_num);
    endfunction

endpackage

// File: rtl/ifu_fetch_perf.sv
// Fetch performance counters: fired output blocks and discarded responses.
module ifu_fetch_perf (
    input  logic        clock,
    input  logic        reset,
    input  logic        block_fire,
    input  logic        resp_drop,
    output logic [31:0] perf_blocks,
    output logic [31:0] perf_drops
);

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_blocks <= 32'd0;
            perf_drops  <= 32'd0;
        end else begin
            if (block_fire) perf_blocks <= perf_blocks + 32'd1;
            if (resp_drop)  perf_drops  <= perf_drops + 32'd1;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Aligned-block instruction fetch with single outstanding request and flush handling.
// Optional IFU_FETCH_PERF_EN adds perf_blocks / perf_drops counter outputs.
module ifu_fetch
    import npc_fetch_pkg::*;
#(
    parameter int unsigned Fetch_Num  = 4,
    parameter logic [31:0] ResetValue = 32'h8000_0000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             pc,
    input  logic                    flush,
    output logic                    pc_update,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [31:0]             req_addr,
    input  logic                    resp_valid,
    input  logic [32*Fetch_Num-1:0] resp_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [32*Fetch_Num-1:0] out_inst,
    output logic [Fetch_Num-1:0]    out_mask
`ifdef IFU_FETCH_PERF_EN
    ,
    output logic [31:0]             perf_blocks,
    output logic [31:0]             perf_drops
`endif
);

    localparam int unsigned OffW  = offset_width(Fetch_Num);
    localparam int unsigned SlotW = OffW - 2;

    fetch_state_e        state;
    fetch_state_e        state_next;
    logic                fire;
    logic                accept;
    logic                load;
    logic                drop;
    logic [31:0]         blk_base;
    logic [SlotW-1:0]    blk_slot;
    logic [Fetch_Num-1:0] slot_mask;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^pc[1:0];

    // Request only when the output register will have room at the next edge.
    assign fire      = out_valid && out_ready;
    assign req_valid = (state == IDLE) && !reset && !flush && (!out_valid || fire);
    assign accept    = req_valid && req_ready;
    assign pc_update = accept;
    assign req_addr  = {pc[31:OffW], OffW'(0)};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = WAIT;
            end
            WAIT: begin
                if (resp_valid) begin
                    load       = !flush;
                    drop       = flush;
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (resp_valid) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slots before the captured entry offset belong to the pre-redirect path.
    always_comb begin
        slot_mask = '0;
        for (int unsigned i = 0; i < Fetch_Num; i++) begin
            slot_mask[i] = (SlotW'(i) >= blk_slot);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blk_base  <= {ResetValue[31:OffW], OffW'(0)};
            blk_slot  <= '0;
            out_valid <= 1'b0;
            out_pc    <= ResetValue;
            out_inst  <= '0;
            out_mask  <= '0;
        end else begin
            if (accept) begin
                blk_base <= {pc[31:OffW], OffW'(0)};
                blk_slot <= pc[OffW-1:2];
            end
            if (load) begin
                out_valid <= 1'b1;
                out_pc    <= blk_base;
                out_inst  <= resp_data;
                out_mask  <= slot_mask;
            end else if (flush || fire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef IFU_FETCH_PERF_EN
    ifu_fetch_perf u_perf (
        .clock       (clock),
        .reset       (reset),
        .block_fire  (fire),
        .resp_drop   (drop),
        .perf_blocks (perf_blocks),
        .perf_drops  (perf_drops)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch (Fetch_Num = 4).
module tb_ifu_fetch;

    logic         clock;
    logic         reset;
    logic [31:0]  pc;
    logic         flush;
    logic         pc_update;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [127:0] out_inst;
    logic [3:0]   out_mask;
`ifdef IFU_FETCH_PERF_EN
    logic [31:0]  perf_blocks;
    logic [31:0]  perf_drops;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DA = 128'h0000_0013_0010_0093_0020_0113_0030_0193;
    localparam logic [127:0] DB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] DC = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
    localparam logic [127:0] DE = 128'h0bad_c0de_feed_face_a5a5_5a5a_0f0f_f0f0;
    localparam logic [127:0] DF = 128'hffff_0000_ffff_0000_1234_5678_9abc_def0;

    ifu_fetch #(
        .Fetch_Num  (4),
        .ResetValue (32'h8000_0000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .flush      (flush),
        .pc_update  (pc_update),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_mask   (out_mask)
`ifdef IFU_FETCH_PERF_EN
        ,
        .perf_blocks(perf_blocks),
        .perf_drops (perf_drops)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        pc         = 32'h8000_0000;
        flush      = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        out_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_mask", out_mask, 0);
        check("rst_out_pc", out_pc, 32'h8000_0000);
        check("rst_out_inst", out_inst, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_pc_update", pc_update, 0);

        // First block from reset vector
        reset     = 1'b0;
        req_ready = 1'b1;
        #1;
        check("a_req_valid", req_valid, 1);
        check("a_req_addr", req_addr, 32'h8000_0000);
        check("a_pc_update", pc_update, 1);
        tick();
        req_ready = 1'b0;
        pc        = 32'h8000_0010;
        #1;
        check("a_wait_pc_update", pc_update, 0);
        check("a_wait_req_valid", req_valid, 0);
        check("a_wait_out_valid", out_valid, 0);
        resp_valid = 1'b1;
        resp_data  = DA;
        tick();
        resp_valid = 1'b0;
        resp_data  = '0;
        #1;
        check("a_out_valid", out_valid, 1);
        check("a_out_pc", out_pc, 32'h8000_0000);
        check("a_out_mask", out_mask, 4'b1111);
        check("a_out_inst", out_inst, DA);

        // Decode stalls: block held, no new request
        req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_req_valid", req_valid, 0);
            check("hold_pc_update", pc_update, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_inst", out_inst, DA);
            check("hold_out_pc", out_pc, 32'h8000_0000);
            tick();
        end

        // Fire and request in the same cycle
        out_ready = 1'b1;
        #1;
        check("b_req_valid", req_valid, 1);
        check("b_req_addr", req_addr, 32'h8000_0010);
        check("b_pc_update", pc_update, 1);
        tick();
        out_ready = 1'b0;
        req_ready = 1'b0;
        pc        = 32'h8000_0020;
        #1;
        check("b_fired_out_valid", out_valid, 0);
        resp_valid = 1'b1;
        resp_data  = DB;
        tick();
        resp_valid = 1'b0;
        #1;
        check("b_out_valid", out_valid, 1);
        check("b_out_pc", out_pc, 32'h8000_0010);
        check("b_out_mask", out_mask, 4'b1111);
        check("b_out_inst", out_inst, DB);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("b_drain_out_valid", out_valid, 0);

        // Redirect into mid-block
        flush     = 1'b1;
        pc        = 32'h8000_0008;
        req_ready = 1'b1;
        #1;
        check("c_flush_req_valid", req_valid, 0);
        check("c_flush_pc_update", pc_update, 0);
        tick();
        flush = 1'b0;
        #1;
        check("c_req_valid", req_valid, 1);
        check("c_req_addr", req_addr, 32'h8000_0000);
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = DC;
        tick();
        resp_valid = 1'b0;
        #1;
        check("c_out_valid", out_valid, 1);
        check("c_out_pc", out_pc, 32'h8000_0000);
        check("c_out_mask", out_mask, 4'b1100);

        // Flush clears a held block
        flush = 1'b1;
        pc    = 32'h8000_0014;
        #1;
        check("d_flush_req_valid", req_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        check("d_flush_out_valid", out_valid, 0);

        // Flush while waiting -> late response dropped
        req_ready = 1'b1;
        #1;
        check("d_req_addr", req_addr, 32'h8000_0010);
        check("d_req_valid", req_valid, 1);
        tick();
        req_ready = 1'b0;
        flush     = 1'b1;
        pc        = 32'h8000_0100;
        tick();
        flush = 1'b0;
        req_ready = 1'b1;
        #1;
        check("drop_req_valid_1", req_valid, 0);
        tick();
        check("drop_req_valid_2", req_valid, 0);
        check("drop_pc_update_2", pc_update, 0);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = DF;
        tick();
        resp_valid = 1'b0;
        #1;
        check("drop_out_valid", out_valid, 0);
        check("drop_idle_req_valid", req_valid, 1);
        check("drop_idle_req_addr", req_addr, 32'h8000_0100);
`ifdef IFU_FETCH_PERF_EN
        check("drop_perf_drops", perf_drops, 1);
`endif

        // Flush coincident with response
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        flush      = 1'b1;
        resp_valid = 1'b1;
        resp_data  = DF;
        pc         = 32'h8000_0204;
        tick();
        flush      = 1'b0;
        resp_valid = 1'b0;
        #1;
        check("coin_out_valid", out_valid, 0);
        check("coin_req_valid", req_valid, 1);
        check("coin_req_addr", req_addr, 32'h8000_0200);
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = DE;
        tick();
        resp_valid = 1'b0;
        #1;
        check("e_out_valid", out_valid, 1);
        check("e_out_pc", out_pc, 32'h8000_0200);
        check("e_out_mask", out_mask, 4'b1110);
        check("e_out_inst", out_inst, DE);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("e_drain_out_valid", out_valid, 0);
`ifdef IFU_FETCH_PERF_EN
        check("e_perf_blocks", perf_blocks, 3);
        check("e_perf_drops", perf_drops, 2);
`endif

        // Reset while waiting, stale response afterwards
        pc        = 32'h8000_0300;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset      = 1'b0;
        resp_valid = 1'b1;
        resp_data  = DF;
        #1;
        check("stale_pc_update", pc_update, 0);
        tick();
        resp_valid = 1'b0;
        #1;
        check("stale_out_valid", out_valid, 0);
        check("stale_out_mask", out_mask, 0);
        check("stale_out_inst", out_inst, 0);
        check("stale_out_pc", out_pc, 32'h8000_0000);
        check("stale_req_valid", req_valid, 1);
`ifdef IFU_FETCH_PERF_EN
        check("stale_perf_blocks", perf_blocks, 0);
        check("stale_perf_drops", perf_drops, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
